// File: rtl/ch_rd_addr_sched_pkg.sv
// ch_sched_pkg: shared FSM states and AR length helper for the read-address scheduler
package ch_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;
  function automatic logic [7:0] arlen_f(int burst_bytes, int beat_bytes);
    return 8'(burst_bytes / beat_bytes - 1);
  endfunction
  localparam logic [7:0] ARLEN = arlen_f(4096, 64);
endpackage

// File: rtl/ch_rd_addr_sched_rr_arbiter.sv
// rr_arbiter: combinational pick of the first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_id,
  output logic          o_any
);
  int w_j;
  // Scan offsets from farthest to nearest so the nearest request at or after ptr wins
  always_comb begin
    o_grant_id = '0;
    o_any = 1'b0;
    w_j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      w_j = (w_j >= N) ? w_j - N : w_j;
      if (i_req[w_j]) begin
        o_grant_id = IW'(w_j);
        o_any = 1'b1;
      end
    end
    o_grant = N'(o_any) << o_grant_id;
  end
endmodule

// File: rtl/ch_rd_addr_sched.sv
// ch_rd_addr_sched: derives per-channel region bases and round-robins AXI AR bursts
module ch_rd_addr_sched
  import ch_sched_pkg::*;
#(
  parameter int NUM_CH      = 16,
  parameter int CH_SHIFT    = 28,
  parameter int BURST_BYTES = 4096,
  parameter int BEAT_BYTES  = 64,
  parameter int CNT_W       = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_start,
  input  logic [63:0]       i_base_ptr,
  input  logic [CNT_W-1:0]  i_num_bursts,
  input  logic [NUM_CH-1:0] i_ch_ready,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [63:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [4:0]        m_arid,
  output logic              o_busy,
  output logic              o_done
);
  localparam int IW = $clog2(NUM_CH);
  state_t r_state;
  logic [63:0] r_base;
  logic [CNT_W-1:0] r_cnt;
  logic [IW-1:0] r_init_ch, r_rr, w_gid, w_hid;
  logic [63:0] r_ptr [NUM_CH];
  logic [CNT_W-1:0] r_rem [NUM_CH];
  logic [NUM_CH-1:0] w_nz, w_elig, w_grant;
  logic w_any;
  logic [63:0] w_addr;
  logic r_arvalid, r_busy, r_done;
  logic [63:0] r_araddr;
  logic [4:0] r_arid;
  assign m_arvalid = r_arvalid;
  assign m_araddr = r_araddr;
  assign m_arid = r_arid;
  assign m_arlen = arlen_f(BURST_BYTES, BEAT_BYTES);
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign w_hid = r_arid[IW-1:0];
  assign w_elig = w_nz & i_ch_ready;
  // Channels with work left, and the address of whichever one the arbiter grants
  always_comb begin
    w_nz = '0;
    w_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_nz[c] = |r_rem[c];
      if (w_grant[c]) w_addr = r_ptr[c];
    end
  end
  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_arb (
    .i_req(w_elig),
    .i_ptr(r_rr),
    .o_grant(w_grant),
    .o_grant_id(w_gid),
    .o_any(w_any)
  );
  // Job FSM: latch job, fill per-channel regions one per cycle, then issue one AR at a time
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_base <= '0;
      r_cnt <= '0;
      r_init_ch <= '0;
      r_rr <= '0;
      r_arvalid <= 1'b0;
      r_araddr <= '0;
      r_arid <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_ptr[c] <= '0;
        r_rem[c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_INIT;
          r_base <= i_base_ptr;
          r_cnt <= i_num_bursts;
          r_init_ch <= '0;
          r_busy <= 1'b1;
        end
        S_INIT: begin
          r_ptr[r_init_ch] <= r_base + (64'(r_init_ch) << CH_SHIFT);
          r_rem[r_init_ch] <= r_cnt;
          r_init_ch <= (r_init_ch == IW'(NUM_CH - 1)) ? '0 : r_init_ch + 1'b1;
          if (r_init_ch == IW'(NUM_CH - 1)) r_state <= S_RUN;
        end
        S_RUN: if (r_arvalid) begin
          if (m_arready) begin
            r_ptr[w_hid] <= r_ptr[w_hid] + 64'(BURST_BYTES);
            r_rem[w_hid] <= r_rem[w_hid] - 1'b1;
            r_rr <= (w_hid == IW'(NUM_CH - 1)) ? '0 : w_hid + 1'b1;
            r_arvalid <= 1'b0;
          end
        end else if (w_any) begin
          r_arvalid <= 1'b1;
          r_araddr <= w_addr;
          r_arid <= 5'(w_gid);
        end else if (~|w_nz) begin
          r_state <= S_DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  a_region_fits: assert property (@(posedge aclk) disable iff (!aresetn)
    (r_state == S_IDLE && i_start) |-> (64'(i_num_bursts) * 64'(BURST_BYTES) <= (64'd1 << CH_SHIFT)));
endmodule

// File: tb/tb_ch_rd_addr_sched.sv
// tb_ch_rd_addr_sched: scoreboard bench with a queue-based round-robin reference model
module tb_ch_rd_addr_sched;
  localparam int N = 4;
  logic aclk = 1'b0, aresetn = 1'b0, i_start = 1'b0, m_arready = 1'b0;
  logic [63:0] i_base_ptr = '0;
  logic [31:0] i_num_bursts = '0;
  logic [N-1:0] i_ch_ready = '0;
  logic m_arvalid, o_busy, o_done;
  logic [63:0] m_araddr;
  logic [7:0] m_arlen;
  logic [4:0] m_arid;
  typedef struct {logic [63:0] a; int id;} ar_t;
  ar_t exp_q[$];
  int checks = 0, errs = 0, cyc = 0, done_cnt = 0, done_cyc = 0, t_start = 0, rdy_mode = 0;
  logic [63:0] m_addr [N];
  int m_rem [N];
  int m_rr = 0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_a = '0;
  logic [4:0] prev_id = '0;

  ch_rd_addr_sched #(.NUM_CH(N), .CH_SHIFT(28), .BURST_BYTES(4096), .BEAT_BYTES(64), .CNT_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .i_start(i_start), .i_base_ptr(i_base_ptr),
    .i_num_bursts(i_num_bursts), .i_ch_ready(i_ch_ready), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge aclk);
    #1;
    m_arready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  always @(negedge aclk) begin : monitor
    ar_t e;
    if (!aresetn) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_arvalid), 1);
        chk("stall_addr", m_araddr, prev_a);
        chk("stall_id", 64'(m_arid), 64'(prev_id));
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_with_pending", 64'(exp_q.size()), 0);
      end
      if (m_arvalid && m_arready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_ar: addr 0x%0h id %0d, none expected", m_araddr, m_arid);
        end else begin
          e = exp_q.pop_front();
          chk("ar_addr", m_araddr, e.a);
          chk("ar_id", 64'(m_arid), 64'(e.id));
          chk("ar_len", 64'(m_arlen), 63);
        end
      end
      prev_stall = m_arvalid && !m_arready;
      prev_a = m_araddr;
      prev_id = m_arid;
    end
  end

  task automatic gen(input logic [N-1:0] mask);
    int c;
    bit found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < N && !found; k++) begin
        c = (m_rr + k) % N;
        if (m_rem[c] > 0 && mask[c]) found = 1'b1;
      end
      if (found) begin
        exp_q.push_back('{a: m_addr[c], id: c});
        m_addr[c] += 64'h1000;
        m_rem[c]--;
        m_rr = (c + 1) % N;
      end
    end
  endtask

  task automatic start_job(input logic [63:0] base, input int bursts);
    @(posedge aclk);
    #1;
    t_start = cyc;
    i_base_ptr = base;
    i_num_bursts = 32'(bursts);
    i_start = 1'b1;
    for (int c = 0; c < N; c++) begin
      m_addr[c] = base + (64'(c) << 28);
      m_rem[c] = bursts;
    end
    @(posedge aclk);
    #1;
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d ARs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input int d0, input int bursts);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    repeat (3) @(negedge aclk);
    chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("busy_after_done", 64'(o_busy), 0);
    if (bursts == 0) chk("zero_job_latency", 64'(done_cyc - t_start), 64'(N + 2));
  endtask

  task automatic run_job(input logic [63:0] base, input int bursts, input logic [N-1:0] mask,
                         input int mode, input bit stall, input bit restart);
    int d0 = done_cnt;
    int n = 0;
    i_ch_ready = mask;
    rdy_mode = stall ? 2 : mode;
    start_job(base, bursts);
    gen(mask);
    if (stall) begin
      while (!m_arvalid && n < 100) begin
        @(negedge aclk);
        n++;
      end
      chk("stall_arvalid_seen", 64'(m_arvalid), 1);
      repeat (10) @(negedge aclk);
      chk("stall_hold_10", 64'(m_arvalid), 1);
      rdy_mode = mode;
    end
    if (restart) begin
      repeat (8) @(posedge aclk);
      #1;
      i_base_ptr = ~base & ~64'hFFF;
      i_start = 1'b1;
      @(posedge aclk);
      #1;
      i_start = 1'b0;
    end
    wait_drain();
    if (mask != '1 && bursts != 0) begin
      repeat (20) @(negedge aclk);
      chk("no_done_partial", 64'(done_cnt), 64'(d0));
      chk("busy_partial", 64'(o_busy), 1);
      gen('1);
      i_ch_ready = '1;
      wait_drain();
    end
    wait_done(d0, bursts);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_arvalid", 64'(m_arvalid), 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arid", 64'(m_arid), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("arlen_const", 64'(m_arlen), 63);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    run_job(64'h1_0000_0000, 2, 4'hF, 0, 1'b0, 1'b0);
    run_job(64'h2_0000_0000, 0, 4'hF, 0, 1'b0, 1'b0);
    run_job(64'h0, 3, 4'b0100, 0, 1'b0, 1'b0);
    run_job(64'h3_0000_0000, 1, 4'hF, 0, 1'b1, 1'b0);
    rdy_mode = 2;
    i_ch_ready = '1;
    start_job(64'h4_0000_0000, 3);
    gen('1);
    n = 0;
    while (!m_arvalid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("reset_pre_arvalid", 64'(m_arvalid), 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("reset_mid_arvalid", 64'(m_arvalid), 0);
    chk("reset_mid_busy", 64'(o_busy), 0);
    chk("reset_mid_araddr", m_araddr, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    m_rr = 0;
    run_job(64'h5_0000_0000, 2, 4'hF, 0, 1'b0, 1'b0);
    run_job(64'h1_0000_0000, 2, 4'hF, 0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++)
      run_job({$urandom, $urandom} & ~64'hFFF, int'($urandom_range(0, 4)),
              N'($urandom_range(1, 15)), 1, 1'b0, 1'b0);
    repeat (5) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
